// File: rtl/mem_pkg.sv
// Shared constants and helpers for the MEM cipher: rotor tables, start keys and
// mod-26 arithmetic, used by both the encryptor and the decryptor.
package mem_pkg;

  typedef logic [0:25][4:0] table_t;

  typedef struct packed {
    logic [4:0] p3;
    logic [4:0] p2;
    logic [4:0] p1;
  } pos_t;

  typedef enum logic [1:0] {
    ROTOR_1,
    ROTOR_2,
    ROTOR_3
  } rotor_e;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;

  // EKMFLGDQVZNTOWYHXUSPAIBRCJ
  localparam table_t R1_FWD = {5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21,
                               5'd25, 5'd13, 5'd19, 5'd14, 5'd22, 5'd24, 5'd7, 5'd23,
                               5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9};
  // AJDKSIRUXBLHWTMCQGZNPYFVOE
  localparam table_t R2_FWD = {5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23,
                               5'd1, 5'd11, 5'd7, 5'd22, 5'd19, 5'd12, 5'd2, 5'd16,
                               5'd6, 5'd25, 5'd13, 5'd15, 5'd24, 5'd5, 5'd21, 5'd14, 5'd4};
  // BDFHJLCPRTXVZNOYEQIWGAKMSU
  localparam table_t R3_FWD = {5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17,
                               5'd19, 5'd23, 5'd21, 5'd25, 5'd13, 5'd14, 5'd24, 5'd4,
                               5'd16, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12, 5'd18, 5'd20};

  // Inverse tables are derived at elaboration so they can never drift from the forward ones.
  function automatic table_t invert(input table_t fwd);
    table_t inv;
    inv = '0;
    for (int i = 0; i < 26; i++) begin
      inv[fwd[i]] = 5'(i);
    end
    return inv;
  endfunction

  localparam table_t R1_INV = invert(R1_FWD);
  localparam table_t R2_INV = invert(R2_FWD);
  localparam table_t R3_INV = invert(R3_FWD);

  localparam pos_t START_KEY [4] = '{
    pos_t'{p3: 5'd0,  p2: 5'd0,  p1: 5'd0},
    pos_t'{p3: 5'd3,  p2: 5'd2,  p1: 5'd1},
    pos_t'{p3: 5'd19, p2: 5'd11, p1: 5'd7},
    pos_t'{p3: 5'd25, p2: 5'd25, p1: 5'd25}
  };

  function automatic logic [4:0] mod26_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  function automatic logic [4:0] mod26_sub(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + 6'd26 - {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  function automatic logic [4:0] inv_lookup(input rotor_e rotor, input logic [4:0] idx);
    logic [4:0] v;
    case (rotor)
      ROTOR_1: v = R1_INV[idx];
      ROTOR_2: v = R2_INV[idx];
      default: v = R3_INV[idx];
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mem_inv_rotor_stage.sv
// One decrypt pipeline stage: inverse rotor lookup then mod-26 position subtract,
// with the byte, pass-through flag and remaining positions registered under a stall enable.
module mem_inv_rotor_stage
  import mem_pkg::*;
#(
  parameter rotor_e ROTOR    = ROTOR_3,
  parameter bit     TO_ASCII = 1'b0,
  parameter int     KEEP_W   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  input  logic              in_pass,
  input  logic [7:0]        in_data,
  input  logic [4:0]        in_pos,
  input  logic [KEEP_W-1:0] in_keep,
  output logic              out_valid,
  output logic              out_pass,
  output logic [7:0]        out_data,
  output logic [KEEP_W-1:0] out_keep
);

  logic [4:0] val;
  logic [7:0] next_data;

  // Letters carry a 0..25 index between stages; non-letters travel untouched.
  always_comb begin
    val       = mod26_sub(inv_lookup(ROTOR, in_data[4:0]), in_pos);
    next_data = {3'b000, val};
    if (TO_ASCII) next_data = next_data + ASCII_A;
    if (in_pass) next_data = in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_pass  <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_pass  <= in_pass;
      out_data  <= next_data;
      out_keep  <= in_keep;
    end
  end

endmodule

// File: rtl/mem_decrypt.sv
// MEM stream decryptor: tags each accepted letter with the odometer rotor positions
// and runs it back through R3inv, R2inv, R1inv in a stallable 3-stage pipeline.
module mem_decrypt
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] setting,
  input  logic       load,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:1] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:1] out_data
);

  pos_t       pos;
  pos_t       pos_next;
  logic [7:0] in_byte;
  logic [7:0] s1_byte;
  logic       is_letter;
  logic       advance;
  logic       accept;

  logic       s1_valid, s1_pass, s2_valid, s2_pass, s3_valid;
  logic [7:0] s1_data, s2_data, s3_data;
  logic [9:0] s1_keep;
  logic [4:0] s2_keep;
  logic       s3_pass_unused;
  logic       s3_keep_unused;

  assign in_byte = in_data;

  // The whole pipeline freezes only when the output register is full and not drained.
  always_comb begin
    is_letter = (in_byte >= ASCII_A) && (in_byte <= ASCII_Z);
    advance   = !(s3_valid && !out_ready);
    in_ready  = !load && advance;
    accept    = in_valid && in_ready;
    s1_byte   = is_letter ? (in_byte - ASCII_A) : in_byte;
  end

  always_comb begin
    pos_next    = pos;
    pos_next.p1 = mod26_add(pos.p1, 5'd1);
    if (pos.p1 == 5'd25) begin
      pos_next.p2 = mod26_add(pos.p2, 5'd1);
      if (pos.p2 == 5'd25) pos_next.p3 = mod26_add(pos.p3, 5'd1);
    end
  end

  // Load wins over stepping; in-flight bytes already hold their own positions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos <= '0;
    end else if (load) begin
      pos <= START_KEY[setting];
    end else if (accept && is_letter) begin
      pos <= pos_next;
    end
  end

  mem_inv_rotor_stage #(.ROTOR(ROTOR_3), .TO_ASCII(1'b0), .KEEP_W(10)) u_s1 (
    .clk      (clk),
    .reset    (reset),
    .en       (advance),
    .in_valid (accept),
    .in_pass  (!is_letter),
    .in_data  (s1_byte),
    .in_pos   (pos.p3),
    .in_keep  ({pos.p2, pos.p1}),
    .out_valid(s1_valid),
    .out_pass (s1_pass),
    .out_data (s1_data),
    .out_keep (s1_keep)
  );

  mem_inv_rotor_stage #(.ROTOR(ROTOR_2), .TO_ASCII(1'b0), .KEEP_W(5)) u_s2 (
    .clk      (clk),
    .reset    (reset),
    .en       (advance),
    .in_valid (s1_valid),
    .in_pass  (s1_pass),
    .in_data  (s1_data),
    .in_pos   (s1_keep[9:5]),
    .in_keep  (s1_keep[4:0]),
    .out_valid(s2_valid),
    .out_pass (s2_pass),
    .out_data (s2_data),
    .out_keep (s2_keep)
  );

  mem_inv_rotor_stage #(.ROTOR(ROTOR_1), .TO_ASCII(1'b1), .KEEP_W(1)) u_s3 (
    .clk      (clk),
    .reset    (reset),
    .en       (advance),
    .in_valid (s2_valid),
    .in_pass  (s2_pass),
    .in_data  (s2_data),
    .in_pos   (s2_keep),
    .in_keep  (1'b0),
    .out_valid(s3_valid),
    .out_pass (s3_pass_unused),
    .out_data (s3_data),
    .out_keep (s3_keep_unused)
  );

  assign out_valid = s3_valid;
  assign out_data  = s3_data;

endmodule

// File: doc/mem_decrypt.md
# mem_decrypt

Streaming decryptor for the Modified Enigma Machine (MEM) cipher: the receive-side counterpart of the MEM encryptor. It accepts ciphertext ASCII bytes over a valid/ready handshake and runs them backward through three inverse rotors in a 3-stage pipeline. It emits plaintext bytes while stepping the rotor positions in lock-step with the encryptor. It sits between the ciphertext source and the plaintext sink, sharing the 2-bit `setting` key with the encryptor.

## Interface
- No parameters; rotor tables and start keys are fixed constants.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `setting` input 2: key select, sampled only on `load`.
- `load` input 1: reload rotor positions from `setting`.
- `in_valid` input 1: ciphertext byte valid.
- `in_ready` output 1: block accepts the byte this cycle.
- `in_data` input [8:1]: ciphertext ASCII.
- `out_valid` output 1: plaintext byte valid.
- `out_ready` input 1: sink accepts the byte.
- `out_data` output [8:1]: plaintext ASCII.

## Operation
- **Letters.** Only `'A'..'Z'` (0x41–0x5A) are letters, with index x = byte − 0x41. All other bytes, including lowercase, pass through unchanged and do not step the rotors.
- **Cipher definition.** Forward encryption is e = R3[(R2[(R1[(x+p1)%26]+p2)%26]+p3)%26].
- **Decryption.** x = (R1inv[(R2inv[(R3inv[e]−p3) mod 26]−p2) mod 26]−p1) mod 26.
  - All arithmetic is 5-bit, mod 26.
  - Subtraction is implemented as add-26-then-conditional-subtract; the result is never ≥ 26.
- **Rotor tables.**
  - R1 = EKMFLGDQVZNTOWYHXUSPAIBRCJ.
  - R2 = AJDKSIRUXBLHWTMCQGZNPYFVOE.
  - R3 = BDFHJLCPRTXVZNOYEQIWGAKMSU.
  - Inverse tables are precomputed constants.
- **Start keys** for `setting`, as (p1,p2,p3): 00 → (0,0,0), 01 → (1,2,3), 10 → (7,11,19), 11 → (25,25,25).
- **Stepping (odometer).**
  - On each accepted letter, the byte is tagged with the current (p1,p2,p3), then p1 increments.
  - When p1 wraps 25 → 0, p2 increments; when p2 also wraps, p3 increments; p3 wraps 25 → 0.
- **Pipeline.**
  - S1 applies R3inv − p3.
  - S2 applies R2inv − p2.
  - S3 applies R1inv − p1 and converts back to ASCII.
  - Each stage carries a valid bit, a pass-through flag, the byte, and the remaining positions.
- **Stall.** The whole pipeline holds when S3 is valid and `out_ready` = 0; there are no bubbles.
- **Ready.** `in_ready` = !`load` && !(S3 valid && !`out_ready`). This combinational `out_ready` → `in_ready` path is intended.
- **Load.**
  - `load` has priority over input: no byte is accepted in a load cycle.
  - Positions take the start key at the next edge.
  - Bytes already in flight keep their tagged positions.

## Timing
- **Reset values.**
  - `out_valid` = 0, `out_data` = 0x00.
  - Positions = (0,0,0); all stage valids = 0.
  - `in_ready` follows its combinational equation.
- **Latency.** 3 cycles from the accept edge to `out_valid` with no backpressure. Throughput is 1 byte/cycle.
- **Handshake.**
  - `out_data` and `out_valid` hold stable while `out_valid` && !`out_ready`.
  - A transfer occurs on any edge with valid && ready.
- **Simultaneous accept and output with S3 stalled.** This cannot happen, because `in_ready` = 0.
- **Reset mid-operation.** All in-flight bytes are discarded immediately and the outputs return to their reset values asynchronously.
- **Load while stalled.** Positions update; the pipeline contents are unchanged.

## Structure
- Package `mem_pkg` holds:
  - the rotor forward and inverse tables as 26-entry 5-bit arrays;
  - the start-key table indexed by `setting`;
  - the ASCII_A constant and a mod-26 add/subtract function.
- One natural sub-module, `mem_inv_rotor_stage`: a table select plus mod-26 subtract, with valid/data registers and a stall enable. It is instantiated three times.
- The encryptor reuses the same package.

## Test plan
- Reset, no `load` (key 000): input "IV" → output "AA"; p1 ends at 2.
- `load` with `setting` 11, then input "KI" → output "AA". The first letter wraps all three positions to (0,0,0).
- Input "I", "-", "V" → output "A", "-", "A". The pass-through byte does not step p1.
- Hold `out_ready` = 0 for 5 cycles with 4 bytes offered:
  - `in_ready` drops once S3 fills;
  - `out_data` stays stable;
  - after release, outputs appear in order with none lost or duplicated.
- Assert `load` together with `in_valid` → `in_ready` = 0 that cycle; the byte is accepted next cycle using the newly loaded key.
- Assert `reset` mid-stream with 3 bytes in flight → `out_valid` falls to 0 without waiting for an edge; the subsequent "I" decrypts to "A".
